// File: rtl/mem_lower_pkg.sv
// rtl/mem_lower_pkg.sv - shared helpers and read-pipeline record for the banked 1R1W memory
package mem_lower_pkg;

    // Bank index carried down the read pipeline; wide enough that an out-of-range
    // address decodes to an index no real bank matches.
    localparam int BANK_IDX_W = 8;

    // Bypass payload width carried with each read; sized for the default word.
    localparam int RD_WIDTH  = 64;
    localparam int RD_MASK_W = 8;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Address width that never collapses to zero bits.
    function automatic int addr_w_f(input int n);
        return (clog2_f(n) < 1) ? 1 : clog2_f(n);
    endfunction

    // Number of write-mask lanes in a word.
    function automatic int mask_w_f(input int width, input int gran);
        return width / gran;
    endfunction

    // Number of macro banks making up the memory.
    function automatic int nbank_f(input int depth, input int bank_depth);
        return depth / bank_depth;
    endfunction

    // One read in flight: which bank to select and the same-cycle write to merge over it.
    typedef struct packed {
        logic                  valid;
        logic [BANK_IDX_W-1:0] bank;
        logic                  collide;
        logic [RD_MASK_W-1:0]  wmask;
        logic [RD_WIDTH-1:0]   wdata;
    } rd_stage_t;

endpackage

// File: rtl/mem_1r1w_bank_model.sv
// rtl/mem_1r1w_bank_model.sv - behavioural BANK_DEPTH x WIDTH masked 1R1W macro with registered read
module mem_1r1w_bank_model
    import mem_lower_pkg::*;
#(
    parameter int BANK_DEPTH = 32,
    parameter int WIDTH      = 64,
    parameter int MASK_GRAN  = 8,
    localparam int MASK_W    = mask_w_f(WIDTH, MASK_GRAN),
    localparam int OFF_W     = addr_w_f(BANK_DEPTH)
) (
    input  logic              clk,
    input  logic              rd_ce_n,
    input  logic [OFF_W-1:0]  rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    input  logic              wr_ce_n,
    input  logic [OFF_W-1:0]  wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [MASK_W-1:0] wr_mask
);

    logic [WIDTH-1:0] mem_q [BANK_DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0] wr_word_d;

    // Read register only loads while the read chip-enable is active.
    always_comb begin
        rd_data_d = rd_data_q;
        if (!rd_ce_n) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Lane merge: masked-out lanes keep the stored bits.
    always_comb begin
        wr_word_d = mem_q[wr_addr];
        for (int i = 0; i < MASK_W; i++) begin
            if (wr_mask[i]) begin
                wr_word_d[i*MASK_GRAN +: MASK_GRAN] = wr_data[i*MASK_GRAN +: MASK_GRAN];
            end
        end
    end

    // Array and read register are not reset, like a real SRAM macro.
    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
        if (!wr_ce_n) begin
            mem_q[wr_addr] <= wr_word_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_1r1w_masked_banked.sv
// rtl/mem_1r1w_masked_banked.sv - banked 1R1W memory with lane masks, write-first bypass and optional output register
module mem_1r1w_masked_banked
    import mem_lower_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int WIDTH      = 64,
    parameter int MASK_GRAN  = 8,
    parameter int BANK_DEPTH = 32,
    parameter int OUT_REG    = 1,
    localparam int MASK_W    = mask_w_f(WIDTH, MASK_GRAN),
    localparam int NBANK     = nbank_f(DEPTH, BANK_DEPTH),
    localparam int ADDR_W    = addr_w_f(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] R0_addr,
    input  logic              R0_en,
    output logic [WIDTH-1:0]  R0_data,
    output logic              R0_valid,
    input  logic [ADDR_W-1:0] W0_addr,
    input  logic              W0_en,
    input  logic [WIDTH-1:0]  W0_data,
    input  logic [MASK_W-1:0] W0_mask
);

    localparam int OFF_W = addr_w_f(BANK_DEPTH);

    logic                  rd_go;
    logic                  wr_go;
    logic                  wr_in_range;
    logic                  collide;
    logic [BANK_IDX_W-1:0] rd_bank;
    logic [BANK_IDX_W-1:0] wr_bank;
    logic [OFF_W-1:0]      rd_off;
    logic [OFF_W-1:0]      wr_off;
    logic [NBANK-1:0]      rd_ce_n;
    logic [NBANK-1:0]      wr_ce_n;
    logic [WIDTH-1:0]      bank_rdata [NBANK];

    rd_stage_t             s1_q;
    rd_stage_t             s1_d;
    logic [WIDTH-1:0]      macro_sel;
    logic [WIDTH-1:0]      merged;
    logic [WIDTH-1:0]      data_q;
    logic [WIDTH-1:0]      data_d;

    // Address decode and per-bank chip enables; requests seen while rst_n is low are dropped.
    // An out-of-range read decodes to a bank index past the last bank, so no bank is enabled
    // and the output mux later yields zero for it.
    always_comb begin
        rd_bank     = BANK_IDX_W'(32'(R0_addr) / BANK_DEPTH);
        wr_bank     = BANK_IDX_W'(32'(W0_addr) / BANK_DEPTH);
        rd_off      = OFF_W'(32'(R0_addr) % BANK_DEPTH);
        wr_off      = OFF_W'(32'(W0_addr) % BANK_DEPTH);
        wr_in_range = 32'(W0_addr) < DEPTH;
        rd_go       = R0_en & rst_n;
        wr_go       = W0_en & rst_n & wr_in_range;
        collide     = rd_go & wr_go & (R0_addr == W0_addr);
        for (int b = 0; b < NBANK; b++) begin
            rd_ce_n[b] = !(rd_go && (rd_bank == BANK_IDX_W'(b)));
            wr_ce_n[b] = !(wr_go && (wr_bank == BANK_IDX_W'(b)));
        end
    end

    for (genvar g = 0; g < NBANK; g++) begin : g_bank
        mem_1r1w_bank_model #(
            .BANK_DEPTH (BANK_DEPTH),
            .WIDTH      (WIDTH),
            .MASK_GRAN  (MASK_GRAN)
        ) u_bank (
            .clk     (clk),
            .rd_ce_n (rd_ce_n[g]),
            .rd_addr (rd_off),
            .rd_data (bank_rdata[g]),
            .wr_ce_n (wr_ce_n[g]),
            .wr_addr (wr_off),
            .wr_data (W0_data),
            .wr_mask (W0_mask)
        );
    end

    // Stage record captured with the macro access: bank select plus the same-cycle write to bypass.
    always_comb begin
        s1_d         = '0;
        s1_d.valid   = rd_go;
        s1_d.bank    = rd_bank;
        s1_d.collide = collide;
        s1_d.wmask   = RD_MASK_W'(W0_mask);
        s1_d.wdata   = RD_WIDTH'(W0_data);
    end

    // Output mux and write-first merge. Only masked-in lanes are overridden: their macro
    // read-during-write value is never trusted, while masked-out lanes were not written.
    always_comb begin
        macro_sel = '0;
        for (int b = 0; b < NBANK; b++) begin
            if (s1_q.bank == BANK_IDX_W'(b)) begin
                macro_sel = bank_rdata[b];
            end
        end
        merged = macro_sel;
        if (s1_q.collide) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (s1_q.wmask[i]) begin
                    merged[i*MASK_GRAN +: MASK_GRAN] = s1_q.wdata[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
        data_d = s1_q.valid ? merged : data_q;
    end

    // Read pipeline stage and last-returned data; both cleared so in-flight reads die on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            data_q <= '0;
        end else begin
            s1_q   <= s1_d;
            data_q <= data_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic valid_q;
        logic valid_d;

        // Valid follows the stage record by one more cycle.
        always_comb begin
            valid_d = s1_q.valid;
        end

        // Registered read valid.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= valid_d;
            end
        end

        assign R0_valid = valid_q;
        assign R0_data  = data_q;
    end else begin : g_out_comb
        assign R0_valid = s1_q.valid;
        assign R0_data  = s1_q.valid ? merged : data_q;
    end

endmodule

// File: tb/tb_mem_1r1w_masked_banked.sv
// tb/tb_mem_1r1w_masked_banked.sv - self-checking bench for two configurations of the banked 1R1W memory
module tb_mem_1r1w_masked_banked;

    logic        clk;
    logic        rst_n;
    logic [5:0]  r_addr;
    logic        r_en;
    logic [5:0]  w_addr;
    logic        w_en;
    logic [63:0] w_data;
    logic [7:0]  w_mask;
    logic [63:0] r0_data_a;
    logic        r0_valid_a;
    logic [63:0] r0_data_b;
    logic        r0_valid_b;

    int checks = 0;
    int errors = 0;

    // Reference: per-configuration word store plus per-lane "known" flags for never-written data.
    logic [63:0] mem [2][64];
    logic [7:0]  kn [2][64];
    int          depth [2];
    logic        pend_v;
    logic [63:0] pend_d;
    logic [7:0]  pend_k;
    logic [63:0] last_d [2];
    logic [7:0]  last_k [2];

    mem_1r1w_masked_banked #(
        .DEPTH(64), .WIDTH(64), .MASK_GRAN(8), .BANK_DEPTH(32), .OUT_REG(1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .R0_addr(r_addr), .R0_en(r_en), .R0_data(r0_data_a), .R0_valid(r0_valid_a),
        .W0_addr(w_addr), .W0_en(w_en), .W0_data(w_data), .W0_mask(w_mask)
    );

    mem_1r1w_masked_banked #(
        .DEPTH(48), .WIDTH(64), .MASK_GRAN(8), .BANK_DEPTH(16), .OUT_REG(0)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .R0_addr(r_addr), .R0_en(r_en), .R0_data(r0_data_b), .R0_valid(r0_valid_b),
        .W0_addr(w_addr), .W0_en(w_en), .W0_data(w_data), .W0_mask(w_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] lanes(input logic [7:0] m);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = {8{m[i]}};
        return r;
    endfunction

    task automatic idle();
        r_en = 1'b0;
        w_en = 1'b0;
    endtask

    task automatic set_write(input logic [5:0] a, input logic [63:0] d, input logic [7:0] m);
        w_en = 1'b1; w_addr = a; w_data = d; w_mask = m;
    endtask

    task automatic set_read(input logic [5:0] a);
        r_en = 1'b1; r_addr = a;
    endtask

    task automatic clear_model_pipe();
        pend_v = 1'b0;
        for (int d = 0; d < 2; d++) begin
            last_d[d] = 64'h0;
            last_k[d] = 8'hFF;
        end
    endtask

    // One clock: predict from the model, advance it, then compare both DUTs after the edge.
    task automatic step();
        logic        nv [2];
        logic [63:0] nd [2];
        logic [7:0]  nk [2];
        logic        ev;
        logic [63:0] ed;
        logic [7:0]  ek;
        logic        av;
        logic [63:0] ad;
        logic [63:0] km;
        for (int d = 0; d < 2; d++) begin
            nv[d] = 1'b0; nd[d] = 64'h0; nk[d] = 8'h00;
            if (rst_n && r_en) begin
                nv[d] = 1'b1;
                if (int'(r_addr) >= depth[d]) begin
                    nd[d] = 64'h0; nk[d] = 8'hFF;
                end else begin
                    nd[d] = mem[d][r_addr]; nk[d] = kn[d][r_addr];
                    if (w_en && w_addr == r_addr) begin
                        nd[d] = (nd[d] & ~lanes(w_mask)) | (w_data & lanes(w_mask));
                        nk[d] = nk[d] | w_mask;
                    end
                end
            end
            if (rst_n && w_en && int'(w_addr) < depth[d]) begin
                mem[d][w_addr] = (mem[d][w_addr] & ~lanes(w_mask)) | (w_data & lanes(w_mask));
                kn[d][w_addr]  = kn[d][w_addr] | w_mask;
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                ev = pend_v; ed = pend_d; ek = pend_k;
                pend_v = nv[0]; pend_d = nd[0]; pend_k = nk[0];
                av = r0_valid_a; ad = r0_data_a;
            end else begin
                ev = nv[1]; ed = nd[1]; ek = nk[1];
                av = r0_valid_b; ad = r0_data_b;
            end
            if (ev) begin
                last_d[d] = ed; last_k[d] = ek;
            end else begin
                ed = last_d[d]; ek = last_k[d];
            end
            checks++;
            if (av !== ev) begin
                errors++;
                $display("FAIL valid dut%0d t=%0t got %b expected %b", d, $time, av, ev);
            end
            km = lanes(ek);
            if (km != 64'h0) begin
                checks++;
                if ((ad & km) !== (ed & km)) begin
                    errors++;
                    $display("FAIL data dut%0d t=%0t got %h expected %h lanes %h", d, $time, ad, ed, ek);
                end
            end
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if (r0_valid_a !== 1'b0 || r0_valid_b !== 1'b0) begin
            errors++;
            $display("FAIL %s valid got %b/%b expected 0/0", name, r0_valid_a, r0_valid_b);
        end
        checks++;
        if (r0_data_a !== 64'h0 || r0_data_b !== 64'h0) begin
            errors++;
            $display("FAIL %s data got %h/%h expected 0/0", name, r0_data_a, r0_data_b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; idle(); r_addr = '0; w_addr = '0; w_data = '0; w_mask = '0;
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_state");
        clear_model_pipe();
        set_read(6'd1); set_write(6'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        step(); step();
        idle();
        rst_n = 1'b1;
        step(); step();
    endtask

    task automatic test_write_read();
        set_write(6'd5, 64'h1122334455667788, 8'hFF); step();
        idle(); set_read(6'd5); step();
        checks++;
        if (r0_valid_b !== 1'b1 || r0_data_b !== 64'h1122334455667788) begin
            errors++;
            $display("FAIL write_read_b got %b %h expected 1 1122334455667788", r0_valid_b, r0_data_b);
        end
        idle(); step();
        checks++;
        if (r0_valid_a !== 1'b1 || r0_data_a !== 64'h1122334455667788) begin
            errors++;
            $display("FAIL write_read_a got %b %h expected 1 1122334455667788", r0_valid_a, r0_data_a);
        end
        step();
    endtask

    task automatic test_collision();
        set_write(6'd40, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF); step();
        set_write(6'd40, 64'h0, 8'h0F); set_read(6'd40); step();
        checks++;
        if (r0_data_b !== 64'hFFFFFFFF00000000) begin
            errors++;
            $display("FAIL collision_b got %h expected ffffffff00000000", r0_data_b);
        end
        idle(); step();
        checks++;
        if (r0_valid_a !== 1'b1 || r0_data_a !== 64'hFFFFFFFF00000000) begin
            errors++;
            $display("FAIL collision_a got %b %h expected 1 ffffffff00000000", r0_valid_a, r0_data_a);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [63:0] beats [4];
        logic [5:0]  addrs [4];
        beats = '{64'hA, 64'hB, 64'hA, 64'hB};
        addrs = '{6'd3, 6'd35, 6'd3, 6'd35};
        set_write(6'd3, 64'hA, 8'hFF); step();
        set_write(6'd35, 64'hB, 8'hFF); step();
        idle();
        for (int i = 0; i < 4; i++) begin
            set_read(addrs[i]); step();
            checks++;
            if (r0_valid_b !== 1'b1 || r0_data_b !== beats[i]) begin
                errors++;
                $display("FAIL b2b_beat%0d got %b %h expected 1 %h", i, r0_valid_b, r0_data_b, beats[i]);
            end
        end
        idle(); step(); step();
    endtask

    task automatic test_out_of_range();
        set_write(6'd2, 64'h2222, 8'hFF); step();
        set_write(6'd50, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF); step();
        idle(); set_read(6'd50); step();
        checks++;
        if (r0_valid_b !== 1'b1 || r0_data_b !== 64'h0) begin
            errors++;
            $display("FAIL oor_read got %b %h expected 1 0", r0_valid_b, r0_data_b);
        end
        set_read(6'd2); step();
        checks++;
        if (r0_data_b !== 64'h2222) begin
            errors++;
            $display("FAIL oor_addr2 got %h expected 2222", r0_data_b);
        end
        idle(); step(); step();
    endtask

    task automatic test_mask_zero();
        set_write(6'd7, 64'h5A5A, 8'hFF); step();
        set_write(6'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00); step();
        idle(); set_read(6'd7); step();
        idle(); step();
        checks++;
        if (r0_data_a !== 64'h5A5A || r0_data_b !== 64'h5A5A) begin
            errors++;
            $display("FAIL mask_zero got %h/%h expected 5a5a", r0_data_a, r0_data_b);
        end
        step();
    endtask

    task automatic test_reset_midread();
        set_read(6'd5); step();
        set_write(6'd5, 64'h0, 8'hFF); set_read(6'd5);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midread_reset");
        clear_model_pipe();
        step(); step();
        idle();
        rst_n = 1'b1;
        step(); step();
        set_read(6'd5); step();
        idle(); step();
        checks++;
        if (r0_data_a !== 64'h1122334455667788) begin
            errors++;
            $display("FAIL reset_write_ignored got %h expected 1122334455667788", r0_data_a);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            r_en   = ($urandom_range(0, 3) != 0);
            w_en   = ($urandom_range(0, 2) != 0);
            r_addr = 6'($urandom_range(0, 63));
            w_addr = ($urandom_range(0, 9) < 3) ? r_addr : 6'($urandom_range(0, 63));
            w_data = {$urandom, $urandom};
            w_mask = 8'($urandom);
            step();
        end
        idle(); step(); step();
    endtask

    initial begin
        depth[0] = 64;
        depth[1] = 48;
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 64; a++) begin
                mem[d][a] = 64'h0;
                kn[d][a]  = 8'h00;
            end
        end
        clear_model_pipe();
        test_reset();
        test_write_read();
        test_collision();
        test_back_to_back();
        test_out_of_range();
        test_mask_zero();
        test_reset_midread();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_1r1w_masked_banked.md
MEM_1R1W_MASKED_BANKED -- requirements
Module: mem_1r1w_masked_banked

Interface
REQ-001 Parameter DEPTH, default 64: total words; SHALL be a multiple of BANK_DEPTH.
REQ-002 Parameter WIDTH, default 64: bits per word; SHALL be a multiple of MASK_GRAN.
REQ-003 Parameter MASK_GRAN, default 8: bits covered by one mask bit; MASK_W = WIDTH/MASK_GRAN.
REQ-004 Parameter BANK_DEPTH, default 32: words per macro bank; NBANK = DEPTH/BANK_DEPTH; ADDR_W = clog2(DEPTH).
REQ-005 Parameter OUT_REG, default 1: 0 or 1, adds an output register stage.
REQ-006 clk  input  1  single clock for read and write; all logic rising-edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 R0_addr  input  ADDR_W  read word address.
REQ-009 R0_en  input  1  read request.
REQ-010 R0_data  output  WIDTH  read data.
REQ-011 R0_valid  output  1  R0_data holds the result of a read issued 1+OUT_REG cycles earlier.
REQ-012 W0_addr  input  ADDR_W  write word address.
REQ-013 W0_en  input  1  write request.
REQ-014 W0_data  input  WIDTH  write data.
REQ-015 W0_mask  input  MASK_W  bit i enables write of W0_data[i*MASK_GRAN +: MASK_GRAN].

Function
REQ-016 Bank select = addr / BANK_DEPTH, bank offset = addr % BANK_DEPTH; only the selected bank is enabled per port; all other banks have chip-enable deasserted.
REQ-017 Write committed on the clk edge where W0_en=1; only masked-in lanes change; W0_mask=0 leaves the word unchanged.
REQ-018 Read latency SHALL be exactly 1+OUT_REG cycles from R0_en=1 to R0_valid=1; back-to-back reads every cycle SHALL be supported with no bubbles.
REQ-019 R0_valid SHALL be 0 in any cycle not corresponding to an issued read; R0_data SHALL hold its last value when R0_valid=0.
REQ-020 Bank-select of each read SHALL be registered alongside the macro access, so the output mux selects the bank addressed in the issuing cycle.
REQ-021 Same-cycle collision (R0_en and W0_en, R0_addr==W0_addr): read returns the new data for masked-in lanes and the prior stored data for masked-out lanes (write-first with lane merge), independent of macro collision behaviour.
REQ-022 Bypass: write address, data, mask and collision flag SHALL be registered for one cycle and merged at the macro output stage.
REQ-023 Address >= DEPTH: write SHALL be ignored; read SHALL return all-zero data with R0_valid=1.
REQ-024 Reads and writes to different addresses in the same cycle SHALL not interfere, including within the same bank.
REQ-025 OUT_REG=0: R0_data driven from the merged macro output; OUT_REG=1: merged value registered before R0_data.

Reset
REQ-026 On rst_n=0, asynchronously: R0_valid=0, R0_data=0, all read-pipeline valids, bank-select and bypass registers cleared.
REQ-027 Memory contents SHALL NOT be reset; reads of never-written locations return unspecified data.
REQ-028 Reset asserted mid-read drops the in-flight read: no R0_valid pulse after rst_n deasserts for a read issued before reset.
REQ-029 R0_en/W0_en SHALL be ignored while rst_n=0; operation resumes on the first rising edge after deassertion.

Structure
REQ-030 Shared package mem_lower_pkg SHALL hold clog2-style helper functions, the MASK_W/NBANK derivation and a typedef for the read-pipeline stage record (valid, bank, collide, wmask, wdata).
REQ-031 One sub-module mem_1r1w_bank_model SHALL model a single BANK_DEPTH x WIDTH masked 1R1W macro (1-cycle registered read, active-low chip enables, per-lane write mask), instantiated NBANK times via generate; swapping in a vendor macro touches only this sub-module.

Verification
REQ-032 Write 0x1122334455667788 mask 0xFF to addr 5, read addr 5 next cycle -> R0_valid after 1+OUT_REG cycles, R0_data=0x1122334455667788.
REQ-033 Addr 40 (bank 1) holds 0xFFFFFFFFFFFFFFFF; write 0x0 mask 0x0F to addr 40 and read addr 40 in same cycle -> R0_data=0xFFFFFFFF00000000.
REQ-034 Reads to addr 3, 35, 3, 35 on consecutive cycles, preloaded 0xA and 0xB -> four consecutive R0_valid=1 beats 0xA,0xB,0xA,0xB, no bubbles.
REQ-035 DEPTH=48, BANK_DEPTH=16: write to addr 50 then read addr 50 -> R0_data=0, R0_valid=1; addr 2 contents unchanged.
REQ-036 Issue read, assert rst_n=0 next cycle for 2 cycles -> R0_valid=0, R0_data=0 immediately and no valid pulse after release.
REQ-037 Write mask 0x00 to addr 7 holding 0x5A5A -> subsequent read returns 0x5A5A.
